// File: rtl/lrwait_bank_queue.sv
// lrwait_bank_queue: bank-side LR-wait reservation unit placed in front of one TCDM SRAM bank.
// Queued LRs to the reserved address are held back and woken when the holder retires its SC.
// Optional feature macro: LRWAIT_TIMEOUT_EN (head reservation expires after TimeoutCycles).
module lrwait_bank_queue #(
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned IdWidth       = 8,
   parameter int unsigned NumWaiters    = 4,
   parameter logic [3:0]  AmoLr         = 4'hA,
   parameter logic [3:0]  AmoSc         = 4'hB,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [AddrWidth-1:0]   req_addr_i,
   input  logic                   req_write_i,
   input  logic [3:0]             req_amo_i,
   input  logic [DataWidth-1:0]   req_data_i,
   input  logic [DataWidth/8-1:0] req_strb_i,
   input  logic [IdWidth-1:0]     req_id_i,
   input  logic                   req_lrwait_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   output logic [DataWidth-1:0]   resp_data_o,
   output logic [IdWidth-1:0]     resp_id_o,
   output logic                   resp_error_o,
   output logic                   resp_lrwait_o,
   output logic                   resp_valid_o,
   input  logic                   resp_ready_i,
   output logic                   mem_req_o,
   output logic                   mem_we_o,
   output logic [AddrWidth-1:0]   mem_addr_o,
   output logic [DataWidth-1:0]   mem_wdata_o,
   output logic [DataWidth/8-1:0] mem_be_o,
   input  logic [DataWidth-1:0]   mem_rdata_i
);

   localparam int unsigned PtrW = $clog2(NumWaiters);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StAccess, StWake, StResp} state_e;
   // What the output register is loaded with once the pending op completes.
   typedef enum logic [1:0] {RkMem, RkZero, RkOne, RkError} rkind_e;

   state_e state_q, state_d;

   // Waiter queue: all entries share one address, so only ids are stored per entry.
   logic [IdWidth-1:0]   id_q [NumWaiters];
   logic [AddrWidth-1:0] head_addr_q, head_addr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 resv_q, resv_d;
   logic                 wake_q, wake_d;

   logic [IdWidth-1:0]   pend_id_q;
   rkind_e               pend_kind_q, kind_sel;

   logic [DataWidth-1:0] resp_data_q;
   logic [IdWidth-1:0]   resp_id_q;
   logic                 resp_error_q, resp_lrwait_q, resp_valid_q;

   logic q_empty, q_full, addr_hit, is_lr, is_sc, is_plain_amo;
   logic accept, lr_enq_head, lr_enq_wait, sc_head, sc_ok, plain, need_mem;
   logic do_enq, do_deq, do_clear, wake_issue, expire;
   logic [IdWidth-1:0] head_id;

   assign q_empty    = (cnt_q == '0);
   assign q_full     = (cnt_q == CntW'(NumWaiters));
   assign head_id    = id_q[rd_ptr_q];
   assign wr_ptr     = rd_ptr_q + cnt_q[PtrW-1:0];
   assign accept     = req_valid_i & req_ready_o;
   assign wake_issue = (state_q == StIdle) & wake_q;

   // Classify the incoming request against the queue state.
   always_comb begin
      addr_hit     = (req_addr_i == head_addr_q);
      is_lr        = req_lrwait_i & (req_amo_i == AmoLr);
      is_sc        = req_lrwait_i & (req_amo_i == AmoSc);
      is_plain_amo = (req_amo_i != 4'h0) & (req_amo_i != AmoLr) & (req_amo_i != AmoSc);
      plain        = ~is_lr & ~is_sc;
      lr_enq_head  = is_lr & q_empty;
      lr_enq_wait  = is_lr & ~q_empty & addr_hit & ~q_full;
      sc_head      = is_sc & ~q_empty & (req_id_i == head_id);
      sc_ok        = sc_head & addr_hit & resv_q;
      need_mem     = lr_enq_head | sc_ok | plain;
      do_enq       = accept & (lr_enq_head | lr_enq_wait);
      do_deq       = (accept & sc_head) | expire;
      do_clear     = accept & plain & (req_write_i | is_plain_amo) & ~q_empty & addr_hit;
      kind_sel     = RkMem;
      if (is_lr && !lr_enq_head) begin
         kind_sel = RkError;
      end else if (is_sc) begin
         kind_sel = sc_ok ? RkZero : RkOne;
      end
   end

`ifdef LRWAIT_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TimeoutCycles) + 1;
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
   logic [TmoW-1:0] tmo_q, tmo_d;

   // Expire only in IDLE with nothing pending, so it never coincides with another queue update.
   assign expire = (state_q == StIdle) & ~wake_q & ~q_empty & (tmo_q == TmoLast);

   // Head lifetime counter: restarts whenever a new head takes over.
   always_comb begin
      tmo_d = tmo_q;
      if (q_empty || do_deq) begin
         tmo_d = '0;
      end else if (tmo_q != TmoLast) begin
         tmo_d = tmo_q + TmoW'(1);
      end
   end

   // Lifetime counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) tmo_q <= '0;
      else         tmo_q <= tmo_d;
   end
`else
   logic unused_timeout;
   assign expire         = 1'b0;
   assign unused_timeout = ^TimeoutCycles;
`endif

   // Queue bookkeeping: enqueue, dequeue with hand-over to the next waiter, reservation clear.
   always_comb begin
      cnt_d       = cnt_q;
      rd_ptr_d    = rd_ptr_q;
      head_addr_d = head_addr_q;
      resv_d      = resv_q;
      wake_d      = wake_q;
      if (wake_issue) wake_d = 1'b0;
      if (do_enq) begin
         cnt_d = cnt_q + CntW'(1);
         if (q_empty) begin
            head_addr_d = req_addr_i;
            resv_d      = 1'b1;
         end
      end
      if (do_deq) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
         cnt_d    = cnt_q - CntW'(1);
         resv_d   = (cnt_q > CntW'(1));
         wake_d   = (cnt_q > CntW'(1));
      end
      if (do_clear) resv_d = 1'b0;
   end

   // Queue state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumWaiters; i++) id_q[i] <= '0;
         head_addr_q <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         resv_q      <= 1'b0;
         wake_q      <= 1'b0;
      end else begin
         if (do_enq) id_q[wr_ptr] <= req_id_i;
         head_addr_q <= head_addr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         resv_q      <= resv_d;
         wake_q      <= wake_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // FSM next state; a silent enqueue leaves the FSM in IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (wake_q) state_d = StWake;
            else if (accept && !lr_enq_wait) state_d = StAccess;
         end
         StAccess: state_d = StResp;
         StWake:   state_d = StResp;
         StResp:   if (resp_ready_i) state_d = StIdle;
      endcase
   end

   // FSM outputs: SRAM strobe and request ready; a pending wake-up beats new requests.
   assign req_ready_o = (state_q == StIdle) & ~wake_q & ~expire;
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (wake_issue) begin
         mem_req_o  = 1'b1;
         mem_addr_o = head_addr_q;
      end else if (accept && need_mem) begin
         mem_req_o   = 1'b1;
         mem_we_o    = sc_ok | (plain & req_write_i);
         mem_addr_o  = req_addr_i;
         mem_wdata_o = req_data_i;
         mem_be_o    = req_strb_i;
      end
   end

   // Remember who the in-flight op answers and what kind of answer it gets.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_id_q   <= '0;
         pend_kind_q <= RkMem;
      end else if (wake_issue) begin
         pend_id_q   <= head_id;
         pend_kind_q <= RkMem;
      end else if (accept) begin
         pend_id_q   <= req_id_i;
         pend_kind_q <= kind_sel;
      end
   end

   // Output register: loaded one cycle after the SRAM op, held until the response handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resp_valid_q  <= 1'b0;
         resp_data_q   <= '0;
         resp_id_q     <= '0;
         resp_error_q  <= 1'b0;
         resp_lrwait_q <= 1'b0;
      end else if (state_q == StAccess || state_q == StWake) begin
         resp_valid_q  <= 1'b1;
         resp_id_q     <= pend_id_q;
         resp_error_q  <= (pend_kind_q == RkError);
         resp_lrwait_q <= (state_q == StWake);
         unique case (pend_kind_q)
            RkMem:   resp_data_q <= mem_rdata_i;
            RkOne:   resp_data_q <= DataWidth'(1);
            RkZero:  resp_data_q <= '0;
            RkError: resp_data_q <= '0;
         endcase
      end else if (resp_valid_q && resp_ready_i) begin
         resp_valid_q <= 1'b0;
      end
   end

   assign resp_valid_o  = resp_valid_q;
   assign resp_data_o   = resp_data_q;
   assign resp_id_o     = resp_id_q;
   assign resp_error_o  = resp_error_q;
   assign resp_lrwait_o = resp_lrwait_q;

endmodule

// File: tb/tb_lrwait_bank_queue.sv
// Bench for lrwait_bank_queue: directed scenarios plus random traffic against a queue-level model.
module tb_lrwait_bank_queue;

   localparam int unsigned NW = 4;
   localparam logic [3:0] AmoLr = 4'hA;
   localparam logic [3:0] AmoSc = 4'hB;
`ifdef LRWAIT_TIMEOUT_EN
   localparam int unsigned Tmo = 16;
`else
   localparam int unsigned Tmo = 1024;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] req_addr = '0;
   logic        req_write = 1'b0;
   logic [3:0]  req_amo = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_strb = '0;
   logic [7:0]  req_id = '0;
   logic        req_lrwait = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] resp_data;
   logic [7:0]  resp_id;
   logic        resp_error, resp_lrwait, resp_valid;
   logic        resp_ready = 1'b0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   always #5 clk = ~clk;

   lrwait_bank_queue #(
      .AddrWidth(32), .DataWidth(32), .IdWidth(8), .NumWaiters(NW),
      .AmoLr(AmoLr), .AmoSc(AmoSc), .TimeoutCycles(Tmo)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_addr_i(req_addr), .req_write_i(req_write), .req_amo_i(req_amo),
      .req_data_i(req_data), .req_strb_i(req_strb), .req_id_i(req_id),
      .req_lrwait_i(req_lrwait), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .resp_data_o(resp_data), .resp_id_o(resp_id), .resp_error_o(resp_error),
      .resp_lrwait_o(resp_lrwait), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
   );

   // SRAM bank behind the unit: read data valid one cycle after the strobe.
   logic [31:0] sram [64];
   always @(posedge clk) begin
      if (mem_req) begin
         mem_rdata <= sram[mem_addr[7:2]];
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) sram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: waiter list, reserved address, reservation flag and memory image.
   int          mq[$];
   logic [31:0] m_haddr;
   bit          m_resv;
   logic [31:0] m_mem [64];

   task automatic model_step(input logic [31:0] addr, input bit wr, input logic [3:0] amo,
                             input logic [31:0] data, input logic [7:0] id, input bit lrw,
                             output bit has_resp, output logic [31:0] e_data, output bit e_err,
                             output bit chk_data, output bit has_wake, output logic [7:0] w_id,
                             output logic [31:0] w_data);
      has_resp = 1; e_data = '0; e_err = 0; chk_data = 1; has_wake = 0; w_id = '0; w_data = '0;
      if (lrw && amo == AmoLr) begin
         if (mq.size() == 0) begin
            mq.push_back(int'(id)); m_haddr = addr; m_resv = 1; e_data = m_mem[addr[7:2]];
         end else if (addr == m_haddr && mq.size() < NW) begin
            mq.push_back(int'(id)); has_resp = 0;
         end else begin
            e_err = 1;
         end
      end else if (lrw && amo == AmoSc) begin
         if (mq.size() > 0 && int'(id) == mq[0]) begin
            if (addr == m_haddr && m_resv) m_mem[addr[7:2]] = data;
            else e_data = 32'd1;
            void'(mq.pop_front());
            m_resv = (mq.size() > 0);
            if (mq.size() > 0) begin
               has_wake = 1; w_id = 8'(mq[0]); w_data = m_mem[m_haddr[7:2]];
            end
         end else begin
            e_data = 32'd1;
         end
      end else begin
         if (wr) begin
            // Read data returned for a store is not defined, so only its metadata is checked.
            chk_data = 0;
            m_mem[addr[7:2]] = data;
            if (mq.size() > 0 && addr == m_haddr) m_resv = 0;
         end else begin
            e_data = m_mem[addr[7:2]];
         end
      end
   endtask

   task automatic take_resp(input string tag, input logic [7:0] e_id, input logic [31:0] e_data,
                            input bit chk_data, input bit e_err, input bit e_lrw, input int stall,
                            input bit chk_lat);
      int lat = 0;
      logic [31:0] snap;
      while (!resp_valid && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      check_val({tag, "_valid"}, resp_valid, 1);
      if (!resp_valid) return;
      if (chk_lat) check_val({tag, "_latency"}, lat, 2);
      check_val({tag, "_id"}, resp_id, e_id);
      check_val({tag, "_error"}, resp_error, e_err);
      check_val({tag, "_lrwait"}, resp_lrwait, e_lrw);
      if (chk_data) check_val({tag, "_data"}, resp_data, e_data);
      snap = resp_data;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check_val({tag, "_stall_valid"}, resp_valid, 1);
         check_val({tag, "_stall_data"}, resp_data, snap);
         check_val({tag, "_stall_ready"}, req_ready, 0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      check_val({tag, "_drained"}, resp_valid, 0);
   endtask

   task automatic send(input string tag, input logic [31:0] addr, input bit wr,
                       input logic [3:0] amo, input logic [31:0] data, input logic [7:0] id,
                       input bit lrw, input int stall);
      bit has_resp, e_err, chk_data, has_wake, seen;
      logic [31:0] e_data, w_data;
      logic [7:0] w_id;
      int w = 0;
      @(negedge clk);
      req_addr = addr; req_write = wr; req_amo = amo; req_data = data; req_id = id;
      req_lrwait = lrw; req_strb = 4'hF; req_valid = 1'b1;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         check_val({tag, "_req_ready"}, req_ready, 1);
         req_valid = 1'b0;
         return;
      end
      model_step(addr, wr, amo, data, id, lrw, has_resp, e_data, e_err, chk_data, has_wake,
                 w_id, w_data);
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (has_resp) begin
         take_resp(tag, id, e_data, chk_data, e_err, 1'b0, stall, 1'b1);
      end else begin
         seen = 0;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            seen |= resp_valid;
         end
         check_val({tag, "_silent"}, seen, 0);
      end
      if (has_wake) take_resp({tag, "_wake"}, w_id, w_data, 1'b1, 1'b0, 1'b1, 0, 1'b0);
   endtask

   initial begin
      logic [31:0] addrs [3];
      int unsigned op;
      logic [31:0] a, d;
      logic [7:0] id;
      int w;
      addrs = '{32'h40, 32'h80, 32'hC0};
      for (int i = 0; i < 64; i++) begin
         sram[i] = 32'h1000 + 32'(i);
         m_mem[i] = 32'h1000 + 32'(i);
      end
      sram[16] = 32'h5; m_mem[16] = 32'h5;
      m_haddr = '0; m_resv = 0;

      repeat (3) @(negedge clk);
      check_val("rst_resp_valid", resp_valid, 0);
      check_val("rst_resp_data", resp_data, 0);
      check_val("rst_resp_id", resp_id, 0);
      check_val("rst_resp_error", resp_error, 0);
      check_val("rst_resp_lrwait", resp_lrwait, 0);
      check_val("rst_mem_req", mem_req, 0);
      rst_n = 1'b1;

`ifdef LRWAIT_TIMEOUT_EN
      send("lr_head", 32'h40, 0, AmoLr, '0, 8'd1, 1, 0);
      send("lr_wait2", 32'h40, 0, AmoLr, '0, 8'd2, 1, 0);
      // Head id 1 never retires; its lifetime runs out and id 2 takes over.
      void'(mq.pop_front());
      m_resv = 1;
      take_resp("tmo_wake", 8'd2, m_mem[16], 1'b1, 1'b0, 1'b1, 0, 1'b0);
      send("tmo_stale_sc", 32'h40, 1, AmoSc, 32'h77, 8'd1, 1, 0);
`else
      send("lr_head", 32'h40, 0, AmoLr, '0, 8'd1, 1, 0);
      send("lr_wait2", 32'h40, 0, AmoLr, '0, 8'd2, 1, 0);
      send("lr_wait3", 32'h40, 0, AmoLr, '0, 8'd3, 1, 0);
      send("sc_ok", 32'h40, 1, AmoSc, 32'h9, 8'd1, 1, 0);
      send("lr_wait4", 32'h40, 0, AmoLr, '0, 8'd4, 1, 0);
      send("lr_wait5", 32'h40, 0, AmoLr, '0, 8'd5, 1, 0);
      send("lr_full", 32'h40, 0, AmoLr, '0, 8'd6, 1, 0);
      send("lr_other_addr", 32'h80, 0, AmoLr, '0, 8'd7, 1, 0);
      send("st_head_addr", 32'h40, 1, 4'h0, 32'h7, 8'd9, 0, 0);
      send("sc_lost_resv", 32'h40, 1, AmoSc, 32'h33, 8'd2, 1, 0);
      send("sc_non_head", 32'h40, 1, AmoSc, 32'h44, 8'd5, 1, 5);
      send("plain_lr_load", 32'h40, 0, AmoLr, '0, 8'd8, 0, 1);

      for (int t = 0; t < 300; t++) begin
         op = $urandom_range(0, 9);
         a  = addrs[$urandom_range(0, 2)];
         id = 8'($urandom_range(1, 6));
         d  = $urandom;
         if (op < 4) begin
            send("rnd_lr", a, 0, AmoLr, d, id, 1, $urandom_range(0, 3));
         end else if (op < 7) begin
            if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
               id = 8'(mq[0]);
               if ($urandom_range(0, 3) != 0) a = m_haddr;
            end
            send("rnd_sc", a, 1, AmoSc, d, id, 1, $urandom_range(0, 3));
         end else if (op == 7) begin
            send("rnd_st", a, 1, 4'h0, d, id, 0, $urandom_range(0, 3));
         end else if (op == 8) begin
            send("rnd_ld", a, 0, 4'h0, d, id, 0, $urandom_range(0, 3));
         end else begin
            send("rnd_plain_sc", a, 0, AmoSc, d, id, 0, $urandom_range(0, 3));
         end
      end

      // Reset while a load is in flight: response dropped and queue flushed.
      @(negedge clk);
      req_addr = 32'h80; req_write = 0; req_amo = 4'h0; req_lrwait = 0; req_id = 8'd3;
      req_strb = 4'hF; req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check_val("midrst_req_ready", req_ready, 1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("midrst_resp_valid", resp_valid, 0);
      check_val("midrst_mem_req", mem_req, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mq.delete();
      m_resv = 0;
      send("post_rst_lr", 32'h80, 0, AmoLr, '0, 8'd1, 1, 0);

      for (int k = 0; k < 3; k++)
         check_val("sram_image", sram[addrs[k][7:2]], m_mem[addrs[k][7:2]]);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
